// File: rtl/pmod_stand_spi_solo_pkg.sv
// -----------------------------------------------------------------------------
// pmod_stand_spi_solo_pkg
// Shared types and constants for the PMOD CLS SPI display path.
//   t_pmod_cls_ascii_line_16 : 16 ASCII characters of one display line
//   t_cls_seq_state          : display sequencer FSM states
//   t_cls_seq_job            : job currently owned by the sequencer
//   c_cls_seq_refresh_bits   : width of the optional periodic refresh counter
// -----------------------------------------------------------------------------
package pmod_stand_spi_solo_pkg;

    typedef logic [127:0] t_pmod_cls_ascii_line_16;

    typedef enum logic [1:0] {
        ST_SEQ_IDLE      = 2'd0,
        ST_SEQ_ISSUE     = 2'd1,
        ST_SEQ_WAIT_ACK  = 2'd2,
        ST_SEQ_WAIT_DONE = 2'd3
    } t_cls_seq_state;

    typedef enum logic [1:0] {
        JOB_CLEAR = 2'd0,
        JOB_LINE1 = 2'd1,
        JOB_LINE2 = 2'd2
    } t_cls_seq_job;

    localparam int c_cls_seq_refresh_bits = 24;

endpackage

// File: rtl/cls_display_sequencer.sv
// -----------------------------------------------------------------------------
// cls_display_sequencer
// Sits in front of the PMOD CLS SPI display driver and owns its three command
// strobes. Jobs (clear > line1 > line2) are issued one at a time through the
// driver's command_ready handshake; a line is rewritten only when its text
// differs from what was last sent, or after a clear request / reset.
//
// Ports
//   i_ext_spi_clk_x        clock
//   i_srst                 synchronous active-high reset
//   i_spi_ce_4x            clock enable; all state advances only when high
//   i_dat_ascii_line1/2    requested line text
//   i_clear_request        level: clear display then rewrite both lines
//   i_cls_command_ready    driver ready
//   o_cmd_wr_clear_display / o_cmd_wr_text_line1 / o_cmd_wr_text_line2
//                          one-ce-wide command strobes
//   o_dat_ascii_line1/2    text snapshot held while the driver consumes it
//   o_busy                 high whenever the FSM is not idle
//   o_update_count         completed driver operations (wraps)
//
// Build option: define CLS_PERIODIC_REFRESH_EN to add a periodic rewrite of
// both lines every parm_refresh_ms (2 ms with parm_fast_simulation=1).
// -----------------------------------------------------------------------------
module cls_display_sequencer
    import pmod_stand_spi_solo_pkg::*;
#(
    parameter int parm_fast_simulation = 0,
    parameter int FCLK_ce              = 2500000,
    parameter int parm_refresh_ms      = 1000
) (
    input  logic                    i_ext_spi_clk_x,
    input  logic                    i_srst,
    input  logic                    i_spi_ce_4x,
    input  t_pmod_cls_ascii_line_16 i_dat_ascii_line1,
    input  t_pmod_cls_ascii_line_16 i_dat_ascii_line2,
    input  logic                    i_clear_request,
    input  logic                    i_cls_command_ready,
    output logic                    o_cmd_wr_clear_display,
    output logic                    o_cmd_wr_text_line1,
    output logic                    o_cmd_wr_text_line2,
    output t_pmod_cls_ascii_line_16 o_dat_ascii_line1,
    output t_pmod_cls_ascii_line_16 o_dat_ascii_line2,
    output logic                    o_busy,
    output logic [7:0]              o_update_count
);

    localparam int c_refresh_max = (parm_fast_simulation != 0) ?
                                   (FCLK_ce / 1000 * 2 - 1) :
                                   (FCLK_ce / 1000 * parm_refresh_ms - 1);

    t_cls_seq_state          state_q, state_d;
    t_cls_seq_job            job_q, job_d;
    logic                    clr_pend_q, clr_pend_d;
    logic                    l1_pend_q, l1_pend_d;
    logic                    l2_pend_q, l2_pend_d;
    t_pmod_cls_ascii_line_16 last1_q, last1_d;
    t_pmod_cls_ascii_line_16 last2_q, last2_d;
    t_pmod_cls_ascii_line_16 dat1_q, dat1_d;
    t_pmod_cls_ascii_line_16 dat2_q, dat2_d;
    logic [7:0]              count_q, count_d;
    logic                    issue_clr, issue_l1, issue_l2;
    logic                    refresh_wrap;

`ifdef CLS_PERIODIC_REFRESH_EN
    logic [c_cls_seq_refresh_bits-1:0] refresh_cnt_q;

    assign refresh_wrap = (refresh_cnt_q == c_cls_seq_refresh_bits'(c_refresh_max));

    always_ff @(posedge i_ext_spi_clk_x) begin
        if (i_srst) begin
            refresh_cnt_q <= '0;
        end else if (i_spi_ce_4x) begin
            refresh_cnt_q <= refresh_wrap ? '0 : refresh_cnt_q + 1'b1;
        end
    end
`else
    logic unused_refresh_cfg;
    assign unused_refresh_cfg = (c_refresh_max == 0);
    assign refresh_wrap       = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        job_d     = job_q;
        dat1_d    = dat1_q;
        dat2_d    = dat2_q;
        last1_d   = last1_q;
        last2_d   = last2_q;
        count_d   = count_q;
        issue_clr = 1'b0;
        issue_l1  = 1'b0;
        issue_l2  = 1'b0;

        case (state_q)
            ST_SEQ_IDLE: begin
                if ((clr_pend_q || l1_pend_q || l2_pend_q) && i_cls_command_ready) begin
                    state_d = ST_SEQ_ISSUE;
                    if (clr_pend_q) begin
                        job_d     = JOB_CLEAR;
                        issue_clr = 1'b1;
                    end else if (l1_pend_q) begin
                        job_d    = JOB_LINE1;
                        issue_l1 = 1'b1;
                    end else begin
                        job_d    = JOB_LINE2;
                        issue_l2 = 1'b1;
                    end
                end
            end
            ST_SEQ_ISSUE:     state_d = ST_SEQ_WAIT_ACK;
            ST_SEQ_WAIT_ACK:  if (!i_cls_command_ready) state_d = ST_SEQ_WAIT_DONE;
            ST_SEQ_WAIT_DONE: begin
                if (i_cls_command_ready) begin
                    state_d = ST_SEQ_IDLE;
                    count_d = count_q + 8'd1;
                end
            end
            default:          state_d = ST_SEQ_IDLE;
        endcase

        // The snapshot is loaded on the edge that enters ISSUE, so it is
        // already valid for the whole strobe period.
        if (issue_l1) begin
            dat1_d  = i_dat_ascii_line1;
            last1_d = i_dat_ascii_line1;
        end
        if (issue_l2) begin
            dat2_d  = i_dat_ascii_line2;
            last2_d = i_dat_ascii_line2;
        end

        // On the issuing edge the line compare is masked: the text being
        // captured is exactly what is being compared, so it is not a change.
        clr_pend_d = (clr_pend_q & ~issue_clr) | i_clear_request;
        l1_pend_d  = (l1_pend_q & ~issue_l1) | i_clear_request | refresh_wrap |
                     (~issue_l1 & (i_dat_ascii_line1 != last1_q));
        l2_pend_d  = (l2_pend_q & ~issue_l2) | i_clear_request | refresh_wrap |
                     (~issue_l2 & (i_dat_ascii_line2 != last2_q));
    end

    always_ff @(posedge i_ext_spi_clk_x) begin
        if (i_srst) begin
            state_q    <= ST_SEQ_IDLE;
            job_q      <= JOB_CLEAR;
            clr_pend_q <= 1'b1;
            l1_pend_q  <= 1'b1;
            l2_pend_q  <= 1'b1;
            last1_q    <= '1;
            last2_q    <= '1;
            dat1_q     <= '0;
            dat2_q     <= '0;
            count_q    <= '0;
        end else if (i_spi_ce_4x) begin
            state_q    <= state_d;
            job_q      <= job_d;
            clr_pend_q <= clr_pend_d;
            l1_pend_q  <= l1_pend_d;
            l2_pend_q  <= l2_pend_d;
            last1_q    <= last1_d;
            last2_q    <= last2_d;
            dat1_q     <= dat1_d;
            dat2_q     <= dat2_d;
            count_q    <= count_d;
        end
    end

    assign o_cmd_wr_clear_display = (state_q == ST_SEQ_ISSUE) && (job_q == JOB_CLEAR);
    assign o_cmd_wr_text_line1    = (state_q == ST_SEQ_ISSUE) && (job_q == JOB_LINE1);
    assign o_cmd_wr_text_line2    = (state_q == ST_SEQ_ISSUE) && (job_q == JOB_LINE2);
    assign o_dat_ascii_line1      = dat1_q;
    assign o_dat_ascii_line2      = dat2_q;
    assign o_busy                 = (state_q != ST_SEQ_IDLE);
    assign o_update_count         = count_q;

endmodule

// File: tb/tb_cls_display_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cls_display_sequencer
// Directed bench for cls_display_sequencer. Expected jobs are queued when the
// stimulus is applied and popped when a strobe appears; a small driver model
// answers each strobe by dropping command_ready for a few ce periods.
// -----------------------------------------------------------------------------
module tb_cls_display_sequencer;
    import pmod_stand_spi_solo_pkg::*;

    typedef struct {
        int           job;   // 0 clear, 1 line1, 2 line2
        logic [127:0] data;
    } exp_t;

`ifdef CLS_PERIODIC_REFRESH_EN
    localparam int exp_refresh = 2;
`else
    localparam int exp_refresh = 0;
`endif

    logic         clk = 1'b0;
    logic         srst = 1'b1;
    logic         ce = 1'b0;
    logic [2:0]   ce_div = 3'd0;
    logic [127:0] line1 = 128'h5448495320495320_4C494E45204F4E45;
    logic [127:0] line2 = 128'h4C494E452054574F_2020202020202041;
    logic         clear_req = 1'b0;
    logic         cls_ready = 1'b0;
    logic         strb_clr, strb_l1, strb_l2, busy;
    logic [127:0] dat1, dat2;
    logic [7:0]   upd_cnt;

    exp_t         exp_q[$];
    int           n_tests = 0;
    int           n_fail = 0;
    int           n_strobes = 0;
    int           refresh_strobes = 0;
    int           exp_cnt = 0;
    logic         drv_en = 1'b0;
    logic         refresh_ok = 1'b0;

    cls_display_sequencer #(
        .parm_fast_simulation(1),
        .FCLK_ce(2500000),
        .parm_refresh_ms(1000)
    ) dut (
        .i_ext_spi_clk_x(clk),
        .i_srst(srst),
        .i_spi_ce_4x(ce),
        .i_dat_ascii_line1(line1),
        .i_dat_ascii_line2(line2),
        .i_clear_request(clear_req),
        .i_cls_command_ready(cls_ready),
        .o_cmd_wr_clear_display(strb_clr),
        .o_cmd_wr_text_line1(strb_l1),
        .o_cmd_wr_text_line2(strb_l2),
        .o_dat_ascii_line1(dat1),
        .o_dat_ascii_line2(dat2),
        .o_busy(busy),
        .o_update_count(upd_cnt)
    );

    always #5 clk = ~clk;

    // One ce pulse every 8 clocks, changed on the falling edge.
    always @(negedge clk) begin
        ce_div = ce_div + 3'd1;
        ce     = (ce_div == 3'd0);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] job_vec(input int job);
        logic [2:0] v;
        v = 3'b000;
        if (job == 0) v = 3'b100;
        else if (job == 1) v = 3'b010;
        else v = 3'b001;
        return v;
    endfunction

    // Monitor plus driver model, evaluated just after every ce edge.
    logic [2:0] prev_s = 3'b000;
    int         hold = 0;
    always @(posedge clk) begin
        if (ce) begin
            logic [2:0] s;
            exp_t       e;
            #1;
            s = {strb_clr, strb_l1, strb_l2};
            if (s != 3'b000) begin
                n_strobes++;
                check("strobe_not_consecutive", {125'd0, prev_s}, 128'd0);
                if (exp_q.size() == 0) begin
                    if (refresh_ok && ((s == 3'b010 && dat1 === line1) ||
                                       (s == 3'b001 && dat2 === line2))) begin
                        refresh_strobes++;
                    end else begin
                        check("unexpected_strobe", {125'd0, s}, 128'd0);
                    end
                end else begin
                    e = exp_q.pop_front();
                    $display("[TB] strobe %b job %0d", s, e.job);
                    check("strobe_job", {125'd0, s}, {125'd0, job_vec(e.job)});
                    if (e.job == 1) check("strobe_data_line1", dat1, e.data);
                    if (e.job == 2) check("strobe_data_line2", dat2, e.data);
                end
            end
            prev_s = s;
            if (!drv_en) begin
                cls_ready = 1'b0;
                hold      = 0;
            end else if (s != 3'b000) begin
                cls_ready = 1'b0;
                hold      = 3;
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) cls_ready = 1'b1;
            end else begin
                cls_ready = 1'b1;
            end
        end
    end

    task automatic wait_ce(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!ce) @(posedge clk);
        end
        #2;
    endtask

    task automatic push(input int job, input logic [127:0] data);
        exp_t e;
        e.job  = job;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic wait_strobe(input string tag, input int budget);
        int n0;
        int k;
        n0 = n_strobes;
        k  = 0;
        while (n_strobes == n0 && k < budget) begin
            wait_ce(1);
            k++;
        end
        check(tag, {127'd0, (n_strobes != n0)}, 128'd1);
    endtask

    // Idle means: nothing expected, FSM idle, driver ready, for 8 ce in a row,
    // which leaves room for any spurious follow-on job to show itself.
    task automatic wait_done(input string tag, input int budget);
        int stable;
        int k;
        stable = 0;
        k      = 0;
        while (stable < 8 && k < budget) begin
            wait_ce(1);
            k++;
            if (exp_q.size() == 0 && !busy && cls_ready) stable++;
            else stable = 0;
        end
        check(tag, {127'd0, (stable >= 8)}, 128'd1);
        check({tag, "_queue_empty"}, exp_q.size(), 128'd0);
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- boot ----------------
        repeat (20) @(posedge clk);
        #2 srst = 1'b0;
        wait_ce(1);
        check("reset_strobes", {125'd0, strb_clr, strb_l1, strb_l2}, 128'd0);
        check("reset_busy", {127'd0, busy}, 128'd0);
        check("reset_count", {120'd0, upd_cnt}, 128'd0);
        check("reset_dat1", dat1, 128'd0);
        check("reset_dat2", dat2, 128'd0);
        wait_ce(100);
        check("boot_hold_busy", {127'd0, busy}, 128'd0);
        push(0, 128'd0);
        push(1, line1);
        push(2, line2);
        exp_cnt = 3;
        drv_en  = 1'b1;
        wait_done("boot_done", 200);
        check("boot_count", {120'd0, upd_cnt}, exp_cnt);
        check("boot_busy", {127'd0, busy}, 128'd0);

        // ---------------- single byte change on line 2 ----------------
        line2[7:0] = 8'h42;
        push(2, line2);
        exp_cnt++;
        wait_strobe("byte_change_strobe", 20);
        check("byte_change_byte0", {120'd0, dat2[7:0]}, 128'h42);
        wait_done("byte_change_done", 200);
        check("byte_change_count", {120'd0, upd_cnt}, exp_cnt);

        // ---------------- line 1 change during WAIT_DONE ----------------
        line1 = 128'h4649525354205445_5854202020202020;
        push(1, line1);
        exp_cnt++;
        wait_strobe("midjob_first_strobe", 20);
        check("midjob_snap_issue", dat1, 128'h4649525354205445_5854202020202020);
        wait_ce(2);
        line1 = 128'h5345434F4E442054_4558542020202020;
        push(1, line1);
        exp_cnt++;
        check("midjob_snap_hold0", dat1, 128'h4649525354205445_5854202020202020);
        wait_ce(1);
        check("midjob_snap_hold1", dat1, 128'h4649525354205445_5854202020202020);
        wait_done("midjob_done", 200);
        check("midjob_count", {120'd0, upd_cnt}, exp_cnt);
        check("midjob_final_dat1", dat1, 128'h5345434F4E442054_4558542020202020);

        // ---------------- clear request plus line 2 change ----------------
        line2     = 128'h434C454152205445_5354202020202020;
        clear_req = 1'b1;
        push(0, 128'd0);
        push(1, line1);
        push(2, line2);
        exp_cnt += 3;
        wait_ce(1);
        clear_req = 1'b0;
        wait_done("clear_change_done", 300);
        check("clear_change_count", {120'd0, upd_cnt}, exp_cnt);

        // ---------------- reset during WAIT_ACK ----------------
        line1 = 128'h5245534554204A4F_4220202020202020;
        push(1, line1);
        wait_strobe("reset_job_strobe", 20);
        wait_ce(1);
        check("reset_job_in_wait_ack_busy", {127'd0, busy}, 128'd1);
        @(negedge clk);
        srst   = 1'b1;
        drv_en = 1'b0;
        @(negedge clk);
        check("midreset_strobes", {125'd0, strb_clr, strb_l1, strb_l2}, 128'd0);
        check("midreset_busy", {127'd0, busy}, 128'd0);
        check("midreset_count", {120'd0, upd_cnt}, 128'd0);
        check("midreset_dat1", dat1, 128'd0);
        repeat (4) @(negedge clk);
        srst = 1'b0;
        wait_ce(5);
        push(0, 128'd0);
        push(1, line1);
        push(2, line2);
        exp_cnt = 3;
        drv_en  = 1'b1;
        wait_done("reboot_done", 200);
        check("reboot_count", {120'd0, upd_cnt}, exp_cnt);

        // ---------------- quiet window: refresh only when built in ----------------
        refresh_ok = 1'b1;
        wait_ce(6000);
        refresh_ok = 1'b0;
        check("refresh_strobe_count", refresh_strobes, exp_refresh);
        wait_done("quiet_done", 100);
        check("quiet_count", {120'd0, upd_cnt}, exp_cnt + exp_refresh);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
